semaforo_cruce: RTL

Two-road intersection traffic-light controller: the parametrised successor to the single-head red/amber/green sequencer. It drives road A (main) and road B (secondary) heads plus a pedestrian "walk" lamp. Phase durations are parameters. It adds all-red clearance intervals, a latched pedestrian request that can shorten A-green, and a night mode with flashing lamps. It sits directly behind the lamp drivers and counts in system clock cycles; any prescaling is external.

---
 rtl/semaforo_cruce.sv | 86 ++++++++
 1 files changed

// File: rtl/semaforo_cruce.sv
// semaforo_cruce: two-road traffic light with all-red clearance, pedestrian phase and night blink
module semaforo_cruce #(
  parameter int CW         = 6,
  parameter int T_VERDE_A  = 40,
  parameter int T_MIN_A    = 10,
  parameter int T_VERDE_B  = 20,
  parameter int T_AMARILLO = 3,
  parameter int T_ROJO     = 2,
  parameter int T_PEATON   = 8,
  parameter int T_DESTELLO = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       peaton,
  input  logic       noche,
  output logic       ra,
  output logic       aa,
  output logic       va,
  output logic       rb,
  output logic       ab,
  output logic       vb,
  output logic       walk,
  output logic [2:0] estado
);
  typedef enum logic [2:0] {
    ROJO_A  = 3'd0,
    VERDE_A = 3'd1,
    AMAR_A  = 3'd2,
    ROJO_B  = 3'd3,
    VERDE_B = 3'd4,
    AMAR_B  = 3'd5,
    PEATON  = 3'd6,
    NOCHE   = 3'd7
  } state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, dur;
  logic          pend_q, pend_d, blink_q, blink_d, fin, entra;
  // Duration of the current phase; in NOCHE it is the blink half-period
  always_comb
    dur = (state_q == VERDE_A) ? CW'(T_VERDE_A) :
          (state_q == AMAR_A || state_q == AMAR_B) ? CW'(T_AMARILLO) :
          (state_q == VERDE_B) ? CW'(T_VERDE_B) :
          (state_q == PEATON) ? CW'(T_PEATON) :
          (state_q == NOCHE) ? CW'(T_DESTELLO) : CW'(T_ROJO);
  assign fin = cnt_q == dur;
  // Phase sequencing; night mode can only start from an all-red phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      ROJO_A:  if (fin) state_d = noche ? NOCHE : VERDE_A;
      VERDE_A: if (fin || (pend_q && cnt_q >= CW'(T_MIN_A))) state_d = AMAR_A;
      AMAR_A:  if (fin) state_d = ROJO_B;
      ROJO_B:  if (fin) state_d = noche ? NOCHE : VERDE_B;
      VERDE_B: if (fin) state_d = AMAR_B;
      AMAR_B:  if (fin) state_d = pend_q ? PEATON : ROJO_A;
      PEATON:  if (fin) state_d = ROJO_A;
      NOCHE:   if (!noche) state_d = ROJO_A;
      default: state_d = ROJO_A;
    endcase
  end
  assign entra   = state_d != state_q;
  assign cnt_d   = (entra || fin) ? CW'(1) : cnt_q + 1'b1;
  assign pend_d  = (noche || state_q == NOCHE || (state_d == PEATON && state_q != PEATON)) ? 1'b0 : (peaton | pend_q);
  assign blink_d = (state_d != NOCHE) ? 1'b0 : (state_q != NOCHE) ? 1'b1 : (fin ? ~blink_q : blink_q);
  // State, phase counter, pedestrian latch and blink bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ROJO_A;
      cnt_q   <= CW'(1);
      pend_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      blink_q <= blink_d;
    end
  assign estado = state_q;
  assign ra     = state_q inside {ROJO_A, ROJO_B, PEATON, VERDE_B, AMAR_B};
  assign rb     = (state_q inside {ROJO_A, ROJO_B, PEATON, VERDE_A, AMAR_A}) || (state_q == NOCHE && blink_q);
  assign aa     = state_q == AMAR_A || (state_q == NOCHE && blink_q);
  assign va     = state_q == VERDE_A;
  assign vb     = state_q == VERDE_B;
  assign ab     = state_q == AMAR_B;
  assign walk   = state_q == PEATON;
endmodule
